// File: rtl/rrf_wr_queue.sv
// rrf_wr_queue: 16-entry result write queue feeding three register-file write
// ports. Results are pushed up to three per cycle, drained in age order with
// same-address hazards broken across cycles, and can be looked up for bypass.
`ifndef ALU_WIDTH
`define ALU_WIDTH 32
`endif

module rrf_wr_queue #(
  parameter int unsigned DATA_WIDTH = `ALU_WIDTH,
  localparam int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] in0_addr,
  input  logic [DATA_WIDTH-1:0] in0_data,
  input  logic                  in0_en,
  input  logic [ADDR_WIDTH-1:0] in1_addr,
  input  logic [DATA_WIDTH-1:0] in1_data,
  input  logic                  in1_en,
  input  logic [ADDR_WIDTH-1:0] in2_addr,
  input  logic [DATA_WIDTH-1:0] in2_data,
  input  logic                  in2_en,
  output logic                  in_ready,
  input  logic                  drain_en,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] write0_addr,
  output logic [DATA_WIDTH-1:0] write0_data,
  output logic                  write0_wen,
  output logic [ADDR_WIDTH-1:0] write1_addr,
  output logic [DATA_WIDTH-1:0] write1_data,
  output logic                  write1_wen,
  output logic [ADDR_WIDTH-1:0] write2_addr,
  output logic [DATA_WIDTH-1:0] write2_data,
  output logic                  write2_wen,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  lookup_hit,
  output logic [DATA_WIDTH-1:0] lookup_data,
  output logic [4:0]            count,
  output logic                  addr_err
);

  localparam int unsigned DEPTH    = 16;
  localparam int unsigned MAX_ADDR = 39;

  // Queue storage and pointers
  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [3:0]            r_head;
  logic [3:0]            r_tail;
  logic [4:0]            r_count;
  logic                  r_addr_err;

  // Registered write-port slots
  logic [ADDR_WIDTH-1:0] r_wr_addr [3];
  logic [DATA_WIDTH-1:0] r_wr_data [3];
  logic [2:0]            r_wen;

  logic [ADDR_WIDTH-1:0] w_in_addr [3];
  logic [DATA_WIDTH-1:0] w_in_data [3];
  logic [2:0]            w_in_en;
  logic [2:0]            w_bad;
  logic [2:0]            w_push_vld;
  logic [1:0]            w_push_pos [3];
  logic [1:0]            w_push_n;
  logic                  w_do_push;
  logic                  w_do_drain;
  logic [3:0]            w_e_idx  [3];
  logic [ADDR_WIDTH-1:0] w_e_addr [3];
  logic [2:0]            w_sel;
  logic [1:0]            w_drain_n;
  logic                  w_hit;
  logic [DATA_WIDTH-1:0] w_ldata;

  assign w_in_addr[0] = in0_addr;
  assign w_in_addr[1] = in1_addr;
  assign w_in_addr[2] = in2_addr;
  assign w_in_data[0] = in0_data;
  assign w_in_data[1] = in1_data;
  assign w_in_data[2] = in2_data;
  assign w_in_en      = {in2_en, in1_en, in0_en};

  assign in_ready   = (r_count <= 5'd13);
  assign w_do_push  = in_ready && !flush;
  assign w_do_drain = drain_en && !flush;

  // Push filtering: illegal addresses are dropped, survivors are compacted
  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_push
      assign w_bad[g]      = w_in_en[g] && (w_in_addr[g] > ADDR_WIDTH'(MAX_ADDR));
      assign w_push_vld[g] = w_do_push && w_in_en[g] && !w_bad[g];
      assign w_e_idx[g]    = r_head + 4'(g);
      assign w_e_addr[g]   = r_addr[w_e_idx[g]];
    end
  endgenerate

  assign w_push_pos[0] = 2'd0;
  assign w_push_pos[1] = 2'(w_push_vld[0]);
  assign w_push_pos[2] = 2'(w_push_vld[0]) + 2'(w_push_vld[1]);
  assign w_push_n      = w_push_pos[2] + 2'(w_push_vld[2]);

  // Drain selection: oldest first, stop at the first address repeat
  always_comb begin
    w_sel    = 3'b000;
    w_sel[0] = (r_count >= 5'd1);
    w_sel[1] = w_sel[0] && (r_count >= 5'd2) && (w_e_addr[1] != w_e_addr[0]);
    w_sel[2] = w_sel[1] && (r_count >= 5'd3) && (w_e_addr[2] != w_e_addr[0])
               && (w_e_addr[2] != w_e_addr[1]);
  end

  assign w_drain_n = w_do_drain ? (2'(w_sel[0]) + 2'(w_sel[1]) + 2'(w_sel[2])) : 2'd0;

  // Pointer, count, error flag and write-port registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head     <= 4'd0;
      r_tail     <= 4'd0;
      r_count    <= 5'd0;
      r_addr_err <= 1'b0;
      r_wen      <= 3'b000;
      for (int k = 0; k < 3; k++) begin
        r_wr_addr[k] <= '0;
        r_wr_data[k] <= '0;
      end
    end else begin
      if (in_ready && (|w_bad)) r_addr_err <= 1'b1;
      if (flush) begin
        r_head  <= r_tail;
        r_count <= 5'd0;
      end else begin
        r_head  <= r_head + 4'(w_drain_n);
        r_tail  <= r_tail + 4'(w_push_n);
        r_count <= r_count + 5'(w_push_n) - 5'(w_drain_n);
      end
      for (int k = 0; k < 3; k++) begin
        r_wen[k] <= w_do_drain && w_sel[k];
        if (w_do_drain && w_sel[k]) begin
          r_wr_addr[k] <= w_e_addr[k];
          r_wr_data[k] <= r_data[w_e_idx[k]];
        end
      end
    end
  end

  // Entry storage: writes land at tail plus compacted position
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst && w_push_vld[k]) begin
        r_addr[r_tail + 4'(w_push_pos[k])] <= w_in_addr[k];
        r_data[r_tail + 4'(w_push_pos[k])] <= w_in_data[k];
      end
    end
  end

  // Bypass lookup: later matches override, so youngest wins
  always_comb begin
    w_hit   = 1'b0;
    w_ldata = '0;
    for (int k = 0; k < 3; k++) begin
      if (r_wen[k] && (r_wr_addr[k] == lookup_addr)) begin
        w_hit   = 1'b1;
        w_ldata = r_wr_data[k];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if ((5'(i) < r_count) && (r_addr[r_head + 4'(i)] == lookup_addr)) begin
        w_hit   = 1'b1;
        w_ldata = r_data[r_head + 4'(i)];
      end
    end
  end

  assign lookup_hit  = w_hit;
  assign lookup_data = w_ldata;
  assign count       = r_count;
  assign addr_err    = r_addr_err;
  assign write0_addr = r_wr_addr[0];
  assign write0_data = r_wr_data[0];
  assign write0_wen  = r_wen[0];
  assign write1_addr = r_wr_addr[1];
  assign write1_data = r_wr_data[1];
  assign write1_wen  = r_wen[1];
  assign write2_addr = r_wr_addr[2];
  assign write2_data = r_wr_data[2];
  assign write2_wen  = r_wen[2];

endmodule
